midi_voice_decoder: RTL

Parametrised multi-voice note decoder between the MIDI burst assembler and the waveform synthesis stage. It captures one burst of up to NUM_VOICES note-on slots and splits each note number into a pitch class (0–11, C..B) and an octave using one shared sequential divide-by-12 unit. It presents all voices together under a valid/ready handshake, with a per-voice active mask.

---
 rtl/midi_voice_pkg.sv | 26 ++
 rtl/note_div12.sv | 49 ++++
 rtl/midi_voice_decoder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/midi_voice_pkg.sv
// Shared constants and enums for the MIDI voice decoder: state encoding,
// pitch-class names and slot field positions.
package midi_voice_pkg;

  localparam int NOTES_PER_OCTAVE = 12;

  // Slot layout: note number in [15:8] (only [14:8] decoded), velocity in [7:0]
  localparam int NOTE_LSB = 8;
  localparam int NOTE_W   = 7;
  localparam int VEL_LSB  = 0;
  localparam int VEL_W    = 8;
  localparam int PITCH_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIVIDE,
    HOLD
  } state_e;

  typedef enum logic [PITCH_W-1:0] {
    PC_C, PC_CS, PC_D, PC_DS, PC_E, PC_F,
    PC_FS, PC_G, PC_GS, PC_A, PC_AS, PC_B
  } pitch_e;

endpackage

// File: rtl/note_div12.sv
// Sequential divide-by-12: start loads the note, then one subtract per cycle
// until the remainder drops below 12 (done).
module note_div12
  import midi_voice_pkg::*;
#(
  parameter int OCT_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [NOTE_W-1:0] note_i,
  output logic [NOTE_W-1:0] rem_o,
  output logic [OCT_W-1:0]  quo_o,
  output logic              done_o
);

  logic [NOTE_W-1:0] rem_q, rem_d;
  logic [OCT_W-1:0]  quo_q, quo_d;

  assign done_o = (rem_q < NOTE_W'(NOTES_PER_OCTAVE));
  assign rem_o  = rem_q;
  assign quo_o  = quo_q;

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    if (start_i) begin
      rem_d = note_i;
      quo_d = '0;
    end else if (!done_o) begin
      rem_d = rem_q - NOTE_W'(NOTES_PER_OCTAVE);
      quo_d = quo_q + OCT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only; all next-state
  // math lives in the _d comb block above.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

// File: rtl/midi_voice_decoder.sv
// Captures a burst of note-on slots and decodes each note into pitch class and
// octave with one shared divider. Optional VELOCITY_ZERO_OFF_EN treats vel 0 as note-off.
module midi_voice_decoder
  import midi_voice_pkg::*;
#(
  parameter int NUM_VOICES = 5,
  parameter int DATA_W     = 21,
  parameter int OCT_W      = 4,
  parameter int CNT_W      = $clog2(NUM_VOICES + 1)
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 burst_valid_in,
  output logic                                 burst_ready_out,
  input  logic [CNT_W-1:0]                     on_msg_count_in,
  input  logic [NUM_VOICES-1:0][DATA_W-1:0]    midi_burst_data_in,
  output logic                                 vals_valid_out,
  input  logic                                 vals_ready_in,
  output logic [NUM_VOICES-1:0]                voice_active_out,
  output logic [NUM_VOICES-1:0][PITCH_W-1:0]   note_value_out,
  output logic [NUM_VOICES-1:0][OCT_W-1:0]     octave_out,
  output logic [NUM_VOICES-1:0][VEL_W-1:0]     note_velocity_out,
  output logic                                 dropped_out
);

  state_e                              state_q, state_d;
  logic [NUM_VOICES-1:0][DATA_W-1:0]   slot_q, slot_d;
  logic [CNT_W-1:0]                    count_q, count_d;
  logic [CNT_W-1:0]                    idx_q, idx_d;
  logic [NUM_VOICES-1:0]               active_q, active_d;
  logic [NUM_VOICES-1:0][PITCH_W-1:0]  note_q, note_d;
  logic [NUM_VOICES-1:0][OCT_W-1:0]    oct_q, oct_d;
  logic [NUM_VOICES-1:0][VEL_W-1:0]    vel_q, vel_d;
  logic                                valid_q, valid_d;
  logic                                dropped_q, dropped_d;

  logic [DATA_W-1:0] cur_slot;
  logic [CNT_W-1:0]  count_clamped;
  logic              last_voice;
  logic              vel_zero;
  logic              accept_out;
  logic              div_start;
  logic              div_done;
  logic [NOTE_W-1:0] div_rem;
  logic [OCT_W-1:0]  div_quo;
  logic              unused_bits;

  assign cur_slot      = slot_q[idx_q];
  assign count_clamped = (on_msg_count_in > CNT_W'(NUM_VOICES)) ? CNT_W'(NUM_VOICES)
                                                                 : on_msg_count_in;
  assign last_voice    = (idx_q == count_q - CNT_W'(1));
  assign vel_zero      = (cur_slot[VEL_LSB +: VEL_W] == '0);
  assign accept_out    = valid_q && vals_ready_in;
  assign unused_bits   = ^{cur_slot[DATA_W-1:NOTE_LSB+NOTE_W], div_rem[NOTE_W-1:PITCH_W], vel_zero};

  note_div12 #(
    .OCT_W (OCT_W)
  ) u_div (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .start_i (div_start),
    .note_i  (cur_slot[NOTE_LSB +: NOTE_W]),
    .rem_o   (div_rem),
    .quo_o   (div_quo),
    .done_o  (div_done)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      // NOTE: the slot store is reset too so a mid-decode reset discards it cleanly.
      slot_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      note_q    <= '0;
      oct_q     <= '0;
      vel_q     <= '0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      note_q    <= note_d;
      oct_q     <= oct_d;
      vel_q     <= vel_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (burst_valid_in) state_d = (count_clamped == '0) ? HOLD : LOAD;
`ifdef VELOCITY_ZERO_OFF_EN
      LOAD:   if (vel_zero) state_d = last_voice ? HOLD : LOAD;
              else          state_d = DIVIDE;
`else
      LOAD:   state_d = DIVIDE;
`endif
      DIVIDE: if (div_done) state_d = last_voice ? HOLD : LOAD;
      HOLD:   if (accept_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slot_d    = slot_q;
    count_d   = count_q;
    idx_d     = idx_q;
    active_d  = active_q;
    note_d    = note_q;
    oct_d     = oct_q;
    vel_d     = vel_q;
    valid_d   = valid_q;
    dropped_d = burst_valid_in && (state_q != IDLE);
    div_start = 1'b0;
    case (state_q)
      IDLE: if (burst_valid_in) begin
        slot_d   = midi_burst_data_in;
        count_d  = count_clamped;
        idx_d    = '0;
        active_d = '0;
        note_d   = '0;
        oct_d    = '0;
        vel_d    = '0;
      end
      LOAD: begin
`ifdef VELOCITY_ZERO_OFF_EN
        // Note-off: fields and mask bit stay cleared, no divide.
        if (vel_zero) begin
          if (last_voice) valid_d = 1'b1;
          else            idx_d   = idx_q + CNT_W'(1);
        end else begin
          div_start = 1'b1;
        end
`else
        div_start = 1'b1;
`endif
      end
      DIVIDE: if (div_done) begin
        note_d[idx_q]   = div_rem[PITCH_W-1:0];
        oct_d[idx_q]    = div_quo;
        vel_d[idx_q]    = cur_slot[VEL_LSB +: VEL_W];
        active_d[idx_q] = 1'b1;
        if (last_voice) valid_d = 1'b1;
        else            idx_d   = idx_q + CNT_W'(1);
      end
      // An empty burst arrives here with valid low; raise it one cycle later.
      HOLD: valid_d = !accept_out;
      default: ;
    endcase
  end

  assign burst_ready_out   = (state_q == IDLE);
  assign vals_valid_out    = valid_q;
  assign voice_active_out  = active_q;
  assign note_value_out    = note_q;
  assign octave_out        = oct_q;
  assign note_velocity_out = vel_q;
  assign dropped_out       = dropped_q;

endmodule
